fetch_stage_hz: RTL and testbench

Parametrised next-generation IF stage for the pipelined RISC-V core. It holds the PC and drives an instruction-memory port that may insert wait states. It provides the IF/ID pipeline register, with hazard-unit stall and flush controls and an explicit decode-valid bit. It sits between the hazard unit / execute-stage redirect and the decode stage.

---
 rtl/fetch_stage_hz.sv | 118 +++++++++++
 tb/tb_fetch_stage_hz.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_hz.sv
// fetch_stage_hz: IF stage holding the PC, driving a wait-state imem port and the IF/ID register.
// Optional FETCH_PERF_EN adds saturating fetch_cnt / bubble_cnt counters.
module fetch_stage_hz #(
   parameter int unsigned       XLEN      = 32,
   parameter logic [XLEN-1:0]   RESET_PC  = '0,
   parameter logic [31:0]       NOP_INSTR = 32'h0000_0013,
   parameter int unsigned       PERF_W    = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            StallF,
   input  logic            StallD,
   input  logic            FlushD,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic            imem_ready,
   output logic [31:0]     InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic            ValidD
`ifdef FETCH_PERF_EN
   ,
   output logic [PERF_W-1:0] fetch_cnt,
   output logic [PERF_W-1:0] bubble_cnt
`endif
);

   logic [XLEN-1:0] pcf_q, pcf_d, pc_plus4_f;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] pcd_q, pcd_d;
   logic [XLEN-1:0] plus4d_q, plus4d_d;
   logic            valid_q, valid_d;
   logic            capture;

   assign pc_plus4_f = pcf_q + XLEN'(4);
   assign capture    = imem_ready & ~StallF & ~PCSrcE;
   assign imem_addr  = pcf_q;

   // Redirect beats stall and wait state; a pending fetch is simply abandoned.
   always_comb begin
      pcf_d = pc_plus4_f;
      if (PCSrcE)
         pcf_d = {PCTargetE[XLEN-1:2], 2'b00};
      else if (StallF || !imem_ready)
         pcf_d = pcf_q;
   end

   always_comb begin
      instr_d  = instr_q;
      pcd_d    = pcd_q;
      plus4d_d = plus4d_q;
      valid_d  = valid_q;
      if (FlushD) begin
         instr_d  = NOP_INSTR;
         pcd_d    = '0;
         plus4d_d = '0;
         valid_d  = 1'b0;
      end else if (!StallD) begin
         instr_d  = capture ? imem_rdata : NOP_INSTR;
         pcd_d    = pcf_q;
         plus4d_d = pc_plus4_f;
         valid_d  = capture;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pcf_q    <= RESET_PC;
         instr_q  <= NOP_INSTR;
         pcd_q    <= '0;
         plus4d_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         pcf_q    <= pcf_d;
         instr_q  <= instr_d;
         pcd_q    <= pcd_d;
         plus4d_q <= plus4d_d;
         valid_q  <= valid_d;
      end
   end

   assign InstrD   = instr_q;
   assign PCD      = pcd_q;
   assign PCPlus4D = plus4d_q;
   assign ValidD   = valid_q;

`ifdef FETCH_PERF_EN
   logic [PERF_W-1:0] fetch_cnt_q, bubble_cnt_q;
   logic              fetch_inc, bubble_inc;

   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (&v) ? v : v + PERF_W'(1);
   endfunction

   assign fetch_inc  = capture & ~FlushD & ~StallD;
   assign bubble_inc = ~imem_ready & ~StallF & ~PCSrcE;

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (fetch_inc)  fetch_cnt_q  <= sat_inc(fetch_cnt_q);
         if (bubble_inc) bubble_cnt_q <= sat_inc(bubble_cnt_q);
      end
   end

   assign fetch_cnt  = fetch_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`else
   // Counter width only matters when the counters exist.
   logic [PERF_W-1:0] unused_perf_w;
   assign unused_perf_w = '0;
`endif

endmodule

// File: tb/tb_fetch_stage_hz.sv
// Scoreboard bench for fetch_stage_hz: main instance at RESET_PC=0 plus a wrap instance at 0xFFFFFFFC.
module tb_fetch_stage_hz;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pcf;
      logic [31:0] instr;
      logic [31:0] pcd;
      logic [31:0] p4;
      logic        v;
   } exp_t;

   typedef struct packed {
      logic        rst;
      logic        sf;
      logic        sd;
      logic        fl;
      logic        src;
      logic [31:0] tgt;
      logic        rdy;
   } stim_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
   logic [31:0] PCTargetE = '0;
   logic        imem_ready = 1'b1;
   logic [31:0] imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;
   logic        ValidD;
   logic [31:0] w_addr, w_rdata, w_instr, w_pcd, w_p4;
   logic        w_valid;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt, bubble_cnt, w_fetch_cnt, w_bubble_cnt;
`endif

   int checks = 0;
   int failures = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hA500_0000;
   endfunction

   assign imem_rdata = mem(imem_addr);
   assign w_rdata    = mem(w_addr);

   fetch_stage_hz #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP), .PERF_W(32)) dut (
      .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ready(imem_ready), .InstrD(InstrD),
      .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
`ifdef FETCH_PERF_EN
      , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
   );

   fetch_stage_hz #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP), .PERF_W(32)) dut_w (
      .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_addr(w_addr),
      .imem_rdata(w_rdata), .imem_ready(imem_ready), .InstrD(w_instr),
      .PCD(w_pcd), .PCPlus4D(w_p4), .ValidD(w_valid)
`ifdef FETCH_PERF_EN
      , .fetch_cnt(w_fetch_cnt), .bubble_cnt(w_bubble_cnt)
`endif
   );

   function automatic stim_t S(input logic r, input logic sf, input logic sd, input logic fl,
                               input logic src, input logic [31:0] tgt, input logic rdy);
      return '{rst: r, sf: sf, sd: sd, fl: fl, src: src, tgt: tgt, rdy: rdy};
   endfunction

   function automatic exp_t E(input logic [31:0] pcf, input logic [31:0] instr,
                              input logic [31:0] pcd, input logic [31:0] p4, input logic v);
      return '{pcf: pcf, instr: instr, pcd: pcd, p4: p4, v: v};
   endfunction

   // Drive one cycle of stimulus, then move to just after the rising edge.
   task automatic apply(input stim_t s);
      rst        = s.rst;
      StallF     = s.sf;
      StallD     = s.sd;
      FlushD     = s.fl;
      PCSrcE     = s.src;
      PCTargetE  = s.tgt;
      imem_ready = s.rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      stim_t stq[$];
      exp_t  etq[$];
      exp_t  e, got;
      stq.push_back(S(0, 0, 0, 0, 0, 0, 1)); etq.push_back(E(0, NOP, 0, 0, 0));
      stq.push_back(S(0, 0, 0, 0, 0, 0, 1)); etq.push_back(E(0, NOP, 0, 0, 0));
      while (stq.size() > 0) begin
         sb.push_back(etq.pop_front());
         apply(stq.pop_front());
         e = sb.pop_front();
         got = E(imem_addr, InstrD, PCD, PCPlus4D, ValidD);
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL reset_hold: got pcf=%h instr=%h pcd=%h p4=%h v=%b want pcf=%h instr=%h pcd=%h p4=%h v=%b",
                     got.pcf, got.instr, got.pcd, got.p4, got.v, e.pcf, e.instr, e.pcd, e.p4, e.v);
         end
      end
      rst = 1'b1;
      #1;
      checks++;
      if (imem_addr !== 32'h0) begin
         failures++;
         $display("FAIL reset_release_addr: got %h want 00000000", imem_addr);
      end
      sb.push_back(E(32'h4, mem(32'h0), 32'h0, 32'h4, 1));
      apply(S(1, 0, 0, 0, 0, 0, 1));
      e = sb.pop_front();
      got = E(imem_addr, InstrD, PCD, PCPlus4D, ValidD);
      checks++;
      if (got !== e) begin
         failures++;
         $display("FAIL reset_first_fetch: got pcf=%h instr=%h pcd=%h p4=%h v=%b want pcf=%h instr=%h pcd=%h p4=%h v=%b",
                  got.pcf, got.instr, got.pcd, got.p4, got.v, e.pcf, e.instr, e.pcd, e.p4, e.v);
      end
   endtask

   task automatic test_stream();
      exp_t e, got;
      for (int i = 1; i <= 3; i++) begin
         sb.push_back(E(32'(4 * (i + 1)), mem(32'(4 * i)), 32'(4 * i), 32'(4 * i + 4), 1));
         apply(S(1, 0, 0, 0, 0, 0, 1));
         e = sb.pop_front();
         got = E(imem_addr, InstrD, PCD, PCPlus4D, ValidD);
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL stream[%0d]: got pcf=%h instr=%h pcd=%h p4=%h v=%b want pcf=%h instr=%h pcd=%h p4=%h v=%b",
                     i, got.pcf, got.instr, got.pcd, got.p4, got.v, e.pcf, e.instr, e.pcd, e.p4, e.v);
         end
      end
   endtask

   task automatic test_wait_state();
      stim_t stq[$];
      exp_t  etq[$];
      exp_t  e, got;
      stq.push_back(S(0, 0, 0, 0, 0, 0, 1)); etq.push_back(E(0, NOP, 0, 0, 0));
      stq.push_back(S(1, 0, 0, 0, 0, 0, 1)); etq.push_back(E(32'h4, mem(32'h0), 32'h0, 32'h4, 1));
      stq.push_back(S(1, 0, 0, 0, 0, 0, 1)); etq.push_back(E(32'h8, mem(32'h4), 32'h4, 32'h8, 1));
      stq.push_back(S(1, 0, 0, 0, 0, 0, 0)); etq.push_back(E(32'h8, NOP, 32'h8, 32'hC, 0));
      stq.push_back(S(1, 0, 0, 0, 0, 0, 0)); etq.push_back(E(32'h8, NOP, 32'h8, 32'hC, 0));
      stq.push_back(S(1, 0, 0, 0, 0, 0, 1)); etq.push_back(E(32'hC, mem(32'h8), 32'h8, 32'hC, 1));
      while (stq.size() > 0) begin
         sb.push_back(etq.pop_front());
         apply(stq.pop_front());
         e = sb.pop_front();
         got = E(imem_addr, InstrD, PCD, PCPlus4D, ValidD);
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL wait_state: got pcf=%h instr=%h pcd=%h p4=%h v=%b want pcf=%h instr=%h pcd=%h p4=%h v=%b",
                     got.pcf, got.instr, got.pcd, got.p4, got.v, e.pcf, e.instr, e.pcd, e.p4, e.v);
         end
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (bubble_cnt !== 32'd2) begin
         failures++;
         $display("FAIL bubble_cnt: got %0d want 2", bubble_cnt);
      end
      checks++;
      if (fetch_cnt !== 32'd3) begin
         failures++;
         $display("FAIL fetch_cnt: got %0d want 3", fetch_cnt);
      end
`endif
   endtask

   task automatic test_redirect_flush();
      stim_t stq[$];
      exp_t  etq[$];
      exp_t  e, got;
      stq.push_back(S(1, 1, 0, 1, 1, 32'h103, 1)); etq.push_back(E(32'h100, NOP, 0, 0, 0));
      stq.push_back(S(1, 0, 0, 0, 0, 0, 1));       etq.push_back(E(32'h104, mem(32'h100), 32'h100, 32'h104, 1));
      stq.push_back(S(1, 0, 0, 0, 1, 32'h202, 0)); etq.push_back(E(32'h200, NOP, 32'h104, 32'h108, 0));
      stq.push_back(S(1, 0, 0, 0, 0, 0, 1));       etq.push_back(E(32'h204, mem(32'h200), 32'h200, 32'h204, 1));
      while (stq.size() > 0) begin
         sb.push_back(etq.pop_front());
         apply(stq.pop_front());
         e = sb.pop_front();
         got = E(imem_addr, InstrD, PCD, PCPlus4D, ValidD);
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL redirect_flush: got pcf=%h instr=%h pcd=%h p4=%h v=%b want pcf=%h instr=%h pcd=%h p4=%h v=%b",
                     got.pcf, got.instr, got.pcd, got.p4, got.v, e.pcf, e.instr, e.pcd, e.p4, e.v);
         end
      end
   endtask

   task automatic test_stall();
      stim_t stq[$];
      exp_t  etq[$];
      exp_t  e, got;
      stq.push_back(S(0, 0, 0, 0, 0, 0, 1)); etq.push_back(E(0, NOP, 0, 0, 0));
      for (int i = 0; i < 8; i++) begin
         stq.push_back(S(1, 0, 0, 0, 0, 0, 1));
         etq.push_back(E(32'(4 * (i + 1)), mem(32'(4 * i)), 32'(4 * i), 32'(4 * i + 4), 1));
      end
      for (int i = 0; i < 3; i++) begin
         stq.push_back(S(1, 1, 1, 0, 0, 0, 1));
         etq.push_back(E(32'h20, mem(32'h1C), 32'h1C, 32'h20, 1));
      end
      stq.push_back(S(1, 1, 1, 1, 0, 0, 1)); etq.push_back(E(32'h20, NOP, 0, 0, 0));
      stq.push_back(S(1, 0, 0, 0, 0, 0, 1)); etq.push_back(E(32'h24, mem(32'h20), 32'h20, 32'h24, 1));
      while (stq.size() > 0) begin
         sb.push_back(etq.pop_front());
         apply(stq.pop_front());
         e = sb.pop_front();
         got = E(imem_addr, InstrD, PCD, PCPlus4D, ValidD);
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL stall: got pcf=%h instr=%h pcd=%h p4=%h v=%b want pcf=%h instr=%h pcd=%h p4=%h v=%b",
                     got.pcf, got.instr, got.pcd, got.p4, got.v, e.pcf, e.instr, e.pcd, e.p4, e.v);
         end
      end
   endtask

   task automatic test_wrap();
      stim_t stq[$];
      exp_t  etq[$];
      exp_t  e, got;
      stq.push_back(S(0, 0, 0, 0, 0, 0, 1)); etq.push_back(E(32'hFFFF_FFFC, NOP, 0, 0, 0));
      stq.push_back(S(1, 0, 0, 0, 0, 0, 1)); etq.push_back(E(32'h0, mem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0, 1));
      stq.push_back(S(1, 0, 0, 0, 0, 0, 1)); etq.push_back(E(32'h4, mem(32'h0), 32'h0, 32'h4, 1));
      while (stq.size() > 0) begin
         sb.push_back(etq.pop_front());
         apply(stq.pop_front());
         e = sb.pop_front();
         got = E(w_addr, w_instr, w_pcd, w_p4, w_valid);
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL wrap: got pcf=%h instr=%h pcd=%h p4=%h v=%b want pcf=%h instr=%h pcd=%h p4=%h v=%b",
                     got.pcf, got.instr, got.pcd, got.p4, got.v, e.pcf, e.instr, e.pcd, e.p4, e.v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_wait_state();
      test_redirect_flush();
      test_stall();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
